bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: number of BCD digits per operand; legal range 1..8.
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port Sub  input  1  mode: 0 = A+B+Cin, 1 = A-B (ten's complement).
REQ-006 SHALL have port Cin  input  1  decimal carry-in; add mode only.
REQ-007 SHALL have port A  input  4*NDIGITS  BCD operand; digit 0 in bits [3:0].
REQ-008 SHALL have port B  input  4*NDIGITS  BCD operand; same packing as A.
REQ-009 SHALL have port Busy  output  1  high while digits are being processed.
REQ-010 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port Result  output  4*NDIGITS  BCD result; same packing as A.
REQ-012 SHALL have port Cout  output  1  add: decimal carry-out; sub: 1 = A>=B (no borrow).
REQ-013 SHALL have port Error  output  1  high when an operand held a digit greater than 9.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE with Start=1 at an edge, SHALL capture A, B, Sub and Cin into internal registers and clear the digit counter; later changes on A, B, Sub and Cin SHALL have no effect on that operation.
REQ-016 At capture, if any 4-bit digit of A or B exceeds 9, SHALL go directly to DONE with Error=1, Result=0 and Cout=0; otherwise SHALL go to RUN with Error=0.
REQ-017 Initial digit carry SHALL be Cin when Sub=0 and 1 when Sub=1 (Cin ignored).
REQ-018 In RUN, each cycle SHALL process exactly one digit i, starting at i=0: b' = B digit when Sub=0, and 9 minus B digit when Sub=1.
REQ-019 Digit step: s = a_i + b' + carry, computed 5 bits wide; if s>9, digit = s-10 (mod 16 via +6) and carry=1; otherwise digit = s and carry=0.
REQ-020 After digit NDIGITS-1 is processed, SHALL enter DONE; the final carry SHALL become Cout.
REQ-021 Result, Cout and Error SHALL update only on entry to DONE; a separate working register SHALL hold partial digits, and the outputs SHALL hold until the next entry to DONE.
REQ-022 Busy SHALL equal (state==RUN); Done SHALL equal (state==DONE), lasting one cycle, after which the FSM SHALL return to IDLE.
REQ-023 Latency: for a valid Start captured at edge k, Done SHALL be high in the cycle after edge k+NDIGITS; for an invalid Start, in the cycle after edge k.
REQ-024 Start SHALL be ignored in RUN and DONE; no queuing. A Start held high SHALL be accepted again on the first IDLE edge after Done.
REQ-025 In Sub mode with Cout=0, Result SHALL be 10^NDIGITS + A - B (ten's complement of the negative difference).
REQ-026 The digit counter SHALL be $clog2(NDIGITS)+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-027 Reset=1 SHALL immediately force IDLE and set Busy=0, Done=0, Result=0, Cout=0, Error=0, with all internal registers cleared, independent of Clock.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no Done pulse; the first Start after Reset deasserts SHALL operate normally.

Verification (NDIGITS=4)
REQ-029 A=9999, B=0001, Sub=0, Cin=0 -> Result=0000, Cout=1, Error=0; Busy high 4 cycles; Done in the cycle after edge k+4.
REQ-030 A=1234, B=5678, Sub=0, Cin=1 -> Result=6913, Cout=0; second case Sub=1, Cin=1, A=0100, B=0042 -> Result=0058, Cout=1.
REQ-031 Sub=1, A=0042, B=0100 -> Result=9942, Cout=0; Sub=1, A=B=5555 -> Result=0000, Cout=1.
REQ-032 A=12A4 (hex digit A), B=0000 -> Error=1, Result=0000, Cout=0; Done in the cycle after the capture edge; Busy never high.
REQ-033 Reset pulsed during the 2nd RUN cycle -> all outputs 0 within the same cycle, no Done; then Start with A=0005, B=0005 -> Result=0010, Cout=0.
REQ-034 Start held high for 20 cycles while operands change every cycle -> operations back-to-back every 6 cycles (capture, 4 RUN, DONE); each Result matches the operands present at its capture edge.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, least significant first.
// Subtraction is A + (nines' complement of B) + 1, giving ten's-complement results.
module bcd_serial_adder #(
    parameter int NDIGITS = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Sub,
    input  logic                 Cin,
    input  logic [4*NDIGITS-1:0] A,
    input  logic [4*NDIGITS-1:0] B,
    output logic                 Busy,
    output logic                 Done,
    output logic [4*NDIGITS-1:0] Result,
    output logic                 Cout,
    output logic                 Error
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    work_q, work_d, result_q, result_d;
    logic            sub_q, sub_d, carry_q, carry_d;
    logic            cout_q, cout_d, error_q, error_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            bad_digit, last_digit, carry_out;
    logic [3:0]      b_eff, digit;
    logic [4:0]      digit_sum;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    assign last_digit = (cnt_q == CW'(NDIGITS - 1));

    // Operands shift right each RUN cycle, so the current digit is always in bits [3:0].
    always_comb begin
        b_eff     = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        digit_sum = 5'(a_q[3:0]) + 5'(b_eff) + 5'(carry_q);
        if (digit_sum > 5'd9) begin
            digit     = digit_sum[3:0] + 4'd6;
            carry_out = 1'b1;
        end else begin
            digit     = digit_sum[3:0];
            carry_out = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (Start) state_d = bad_digit ? DONE : RUN;
            RUN:  if (last_digit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == RUN);
        Done = (state_q == DONE);
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        cout_d   = cout_q;
        error_d  = error_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = Sub;
                    carry_d = Sub ? 1'b1 : Cin;
                    cnt_d   = '0;
                    work_d  = '0;
                    if (bad_digit) begin
                        result_d = '0;
                        cout_d   = 1'b0;
                        error_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = carry_out;
                work_d  = (work_q >> 4) | (W'(digit) << (W - 4));
                if (last_digit) begin
                    result_d = work_d;
                    cout_d   = carry_out;
                    error_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            error_q  <= error_d;
        end
    end

    assign Result = result_q;
    assign Cout   = cout_q;
    assign Error  = error_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: decimal-arithmetic model plus a per-cycle
// compare process for Busy/Done/Result/Cout/Error timing.
module tb_bcd_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        int           cap;
        logic [W-1:0] result;
        logic         cout;
        logic         err;
    } exp_t;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         Sub   = 1'b0;
    logic         Cin   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Busy, Done, Cout, Error;
    logic [W-1:0] Result;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t pending[$];
    exp_t last_out;

    bcd_serial_adder #(.NDIGITS(N)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub), .Cin(Cin),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result),
        .Cout(Cout), .Error(Error)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Plain decimal arithmetic on whole operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t   e;
        longint p = 1;
        longint s;
        e.cap = 0; e.result = '0; e.cout = 1'b0; e.err = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = p * 10;
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e.err = 1'b1;
        end
        if (e.err) return e;
        if (!sub) begin
            s = bcd2int(a) + bcd2int(b) + longint'(cin);
            e.cout = (s >= p);
        end else begin
            s = bcd2int(a) - bcd2int(b) + p;
            e.cout = (bcd2int(a) >= bcd2int(b));
        end
        e.result = int2bcd(s % p);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Per-cycle compare against the expected-operation queue.
    always @(negedge Clock) begin
        logic exp_busy;
        exp_busy = 1'b0;
        if (!Reset && pending.size() > 0 && cyc == (pending[0].err ? pending[0].cap : pending[0].cap + N)) begin
            check("done_pulse", 32'(Done), 32'd1);
            last_out = pending[0];
            void'(pending.pop_front());
        end else begin
            check("done_idle", 32'(Done), 32'd0);
        end
        if (!Reset && pending.size() > 0 && !pending[0].err && cyc >= pending[0].cap && cyc < pending[0].cap + N)
            exp_busy = 1'b1;
        check("busy", 32'(Busy), 32'(exp_busy));
        check("result", 32'(Result), 32'(last_out.result));
        check("cout", 32'(Cout), 32'(last_out.cout));
        check("error", 32'(Error), 32'(last_out.err));
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
        exp_t e;
        e = model(a, b, sub, cin);
        @(negedge Clock);
        A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
        @(posedge Clock);
        #1;
        e.cap = cyc;
        pending.push_back(e);
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Sub = ~sub; Cin = ~cin;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && pending.size() > 0; i++) begin
            @(negedge Clock);
            #1;
        end
        check("op_completed", 32'(pending.size()), 32'd0);
        pending.delete();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic cin, input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_e);
        exp_t m;
        m = model(a, b, sub, cin);
        check("model_result", 32'(m.result), 32'(exp_r));
        check("model_cout", 32'(m.cout), 32'(exp_c));
        check("model_error", 32'(m.err), 32'(exp_e));
        launch(a, b, sub, cin);
        wait_idle();
    endtask

    initial begin
        last_out.cap = 0; last_out.result = '0; last_out.cout = 1'b0; last_out.err = 1'b0;
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6913, 1'b0, 1'b0);
        run_op(16'h0100, 16'h0042, 1'b1, 1'b1, 16'h0058, 1'b1, 1'b0);
        run_op(16'h0042, 16'h0100, 1'b1, 1'b0, 16'h9942, 1'b0, 1'b0);
        run_op(16'h5555, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
        run_op(16'h0000, 16'h9999, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op(16'h0123, 16'h0F00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op(16'h4821, 16'h3179, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0);

        // Abort in the second RUN cycle; outputs must clear without a clock edge.
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_result", 32'(Result), 32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        check("abort_error", 32'(Error), 32'd0);
        pending.delete();
        last_out.result = '0; last_out.cout = 1'b0; last_out.err = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (8) @(negedge Clock);
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

        // Start held high with operands changing every cycle: captures every 6 edges.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            logic         s, c;
            exp_t         e;
            a = rand_bcd(); b = rand_bcd();
            s = 1'($urandom); c = 1'($urandom);
            @(negedge Clock);
            A = a; B = b; Sub = s; Cin = c; Start = 1'b1;
            @(posedge Clock);
            #1;
            if (i % 6 == 0) begin
                e = model(a, b, s, c);
                e.cap = cyc;
                pending.push_back(e);
            end
        end
        @(negedge Clock);
        Start = 1'b0;
        wait_idle();

        repeat (3) @(negedge Clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
